// File: rtl/dpram_fifo_ctrl_if.sv
// Producer/consumer stream bundle for the dual-port-RAM FIFO controller.
// master = the environment side, slave = the controller.
interface dpram_fifo_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
);
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W:0]   count;

  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data, count
  );

  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data, count
  );
endinterface

// File: rtl/dpram_fifo_ctrl.sv
// Stream FIFO on an external 64x8 dual-port RAM: port A writes, port B reads,
// with a 2-entry prefetch buffer hiding the 1-cycle registered read.
module dpram_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  dpram_fifo_ctrl_if.slave  s,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [DATA_W-1:0] ram_data_a,
  output logic              ram_we_a,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic              ram_we_b,
  input  logic [DATA_W-1:0] ram_q_b
);
  localparam int UW = ADDR_W + 1;

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [UW-1:0]     ram_used;
  logic              inflight;
  logic [1:0]        occ;
  logic [DATA_W-1:0] slot0, slot1;

  logic       push, pop, fetch;
  logic [2:0] demand;
  logic [1:0] occ_shift;

  assign s.wr_ready = !rst && (ram_used < UW'(DEPTH));
  assign push       = s.wr_valid && s.wr_ready;
  assign pop        = s.rd_valid && s.rd_ready;

  // Buffer slots already spoken for once this cycle's pop leaves; only
  // pre-edge ram_used counts, so a word is never read in its write cycle.
  assign demand    = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign fetch     = (ram_used != '0) && (demand < 3'd2);
  assign occ_shift = occ - {1'b0, pop};

  assign ram_we_a   = push;
  assign ram_addr_a = wr_ptr;
  assign ram_data_a = s.wr_data;
  assign ram_addr_b = rd_ptr;
  assign ram_we_b   = 1'b0;

  assign s.rd_valid = (occ != 2'd0);
  assign s.rd_data  = slot0;
  assign s.count    = ram_used + UW'(inflight) + UW'(occ);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ram_used <= '0;
      inflight <= 1'b0;
      occ      <= 2'd0;
      slot0    <= '0;
      slot1    <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + ADDR_W'(1);
      if (fetch) rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push, fetch})
        2'b10:   ram_used <= ram_used + UW'(1);
        2'b01:   ram_used <= ram_used - UW'(1);
        default: ram_used <= ram_used;
      endcase
      inflight <= fetch;
      occ      <= occ_shift + {1'b0, inflight};
      if (pop) slot0 <= slot1;
      // Returning word lands in the first free slot after the pop shift.
      if (inflight) begin
        if (occ_shift == 2'd0) slot0 <= ram_q_b;
        else                   slot1 <= ram_q_b;
      end
    end
  end
endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Randomized scoreboard bench for dpram_fifo_ctrl with a behavioural RAM
// (registered port-B read, old data on cross-port collision).
module tb_dpram_fifo_ctrl;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dpram_fifo_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  logic [ADDR_W-1:0] ram_addr_a, ram_addr_b;
  logic [DATA_W-1:0] ram_data_a, ram_q_b;
  logic              ram_we_a, ram_we_b;

  dpram_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .s(bus),
    .ram_addr_a(ram_addr_a), .ram_data_a(ram_data_a), .ram_we_a(ram_we_a),
    .ram_addr_b(ram_addr_b), .ram_we_b(ram_we_b), .ram_q_b(ram_q_b)
  );

  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
    ram_q_b <= mem[ram_addr_b];
  end

  logic [DATA_W-1:0] model [$];
  int npass = 0, ntot = 0, pop_total = 0;
  bit last_push, last_pop;
  logic [DATA_W-1:0] last_data;

  // One clock: scoreboard checks before the edge, then advance to edge+1.
  task automatic cycle();
    bit pu, po, r;
    @(negedge clk);
    r  = rst;
    pu = bus.wr_valid && bus.wr_ready;
    po = bus.rd_valid && bus.rd_ready;
    last_push = pu; last_pop = po; last_data = bus.rd_data;
    if (!r) begin
      ntot++;
      if (bus.count !== 7'(model.size()))
        $display("FAIL count: got %0d want %0d", bus.count, model.size());
      else npass++;
      ntot++;
      if (ram_we_b !== 1'b0 || model.size() > DEPTH + 2)
        $display("FAIL bounds: we_b=%b held=%0d", ram_we_b, model.size());
      else npass++;
      if (po) begin
        ntot++;
        if (model.size() == 0)
          $display("FAIL order: got %h want <empty>", bus.rd_data);
        else if (bus.rd_data !== model[0])
          $display("FAIL order: got %h want %h", bus.rd_data, model[0]);
        else npass++;
        if (model.size() != 0) void'(model.pop_front());
        pop_total++;
      end
      if (pu) model.push_back(bus.wr_data);
    end
    @(posedge clk);
    if (r) model.delete();
    #1;
  endtask

  task automatic do_reset();
    bus.wr_valid = 1'b0; bus.rd_ready = 1'b0; bus.wr_data = '0;
    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    #1;
  endtask

  task automatic drain(input int bound, output int pops);
    int n;
    pops = 0; n = 0;
    bus.wr_valid = 1'b0; bus.rd_ready = 1'b1;
    while ((model.size() != 0 || bus.rd_valid) && n < bound) begin
      cycle(); n++;
      if (last_pop) pops++;
    end
    ntot++;
    if (n >= bound) $display("FAIL drain_timeout: held=%0d after %0d cycles", model.size(), n);
    else npass++;
  endtask

  task automatic test_reset();
    bus.wr_valid = 1'b1; bus.wr_data = 8'h33; bus.rd_ready = 1'b1;
    rst = 1'b1;
    cycle(); cycle();
    ntot++;
    if (bus.wr_ready !== 1'b0 || bus.rd_valid !== 1'b0 || bus.count !== 7'd0 || bus.rd_data !== 8'h00)
      $display("FAIL reset_state: wr_ready=%b rd_valid=%b count=%0d rd_data=%h want 0 0 0 00",
               bus.wr_ready, bus.rd_valid, bus.count, bus.rd_data);
    else npass++;
    bus.wr_valid = 1'b0;
    rst = 1'b0; #1;
    ntot++;
    if (bus.wr_ready !== 1'b1) $display("FAIL reset_release: wr_ready=%b want 1", bus.wr_ready);
    else npass++;
  endtask

  task automatic test_single();
    int pops;
    do_reset();
    bus.rd_ready = 1'b1; bus.wr_valid = 1'b1; bus.wr_data = 8'hA5;
    cycle();                 // push edge E0
    bus.wr_valid = 1'b0;
    ntot++;
    if (bus.rd_valid !== 1'b0) $display("FAIL single_lat1: rd_valid=%b want 0", bus.rd_valid);
    else npass++;
    cycle();                 // E1
    ntot++;
    if (bus.rd_valid !== 1'b0) $display("FAIL single_lat2: rd_valid=%b want 0", bus.rd_valid);
    else npass++;
    cycle();                 // E2
    ntot++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'hA5)
      $display("FAIL single_out: rd_valid=%b rd_data=%h want 1 a5", bus.rd_valid, bus.rd_data);
    else npass++;
    cycle();
    ntot++;
    if (!last_pop || bus.count !== 7'd0)
      $display("FAIL single_pop: popped=%b count=%0d want 1 0", last_pop, bus.count);
    else npass++;
    drain(10, pops);
  endtask

  task automatic test_fill();
    int acc, pops;
    do_reset();
    acc = 0;
    bus.rd_ready = 1'b0; bus.wr_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      bus.wr_data = 8'(acc);
      cycle();
      if (last_push) acc++;
    end
    ntot++;
    if (acc != DEPTH + 2 || bus.wr_ready !== 1'b0 || bus.count !== 7'(DEPTH + 2))
      $display("FAIL fill: accepted=%0d wr_ready=%b count=%0d want 66 0 66", acc, bus.wr_ready, bus.count);
    else npass++;
    drain(200, pops);
    ntot++;
    if (pops != DEPTH + 2) $display("FAIL fill_drain: pops=%0d want 66", pops);
    else npass++;
  endtask

  task automatic test_stream();
    int bubbles, start, pops;
    do_reset();
    bubbles = 0;
    start = pop_total;
    bus.rd_ready = 1'b1; bus.wr_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      bus.wr_data = 8'(i);
      cycle();
      if (!last_push || (i >= 3 && !last_pop)) bubbles++;
    end
    drain(20, pops);
    ntot++;
    if (bubbles != 0 || pop_total - start != 200)
      $display("FAIL stream: bubbles=%0d words=%0d want 0 200", bubbles, pop_total - start);
    else npass++;
  endtask

  task automatic test_backpressure();
    int pushed, start, n, pops;
    do_reset();
    pushed = 0; n = 0;
    start = pop_total;
    while (pushed < 1000 && n < 20000) begin
      bus.wr_valid = ($urandom_range(0, 3) != 0);
      bus.wr_data  = 8'($urandom);
      bus.rd_ready = ($urandom_range(0, 3) != 0);
      cycle(); n++;
      if (last_push) pushed++;
    end
    drain(200, pops);
    ntot++;
    if (pushed != 1000 || pop_total - start != 1000)
      $display("FAIL backpressure: pushed=%0d popped=%0d want 1000 1000", pushed, pop_total - start);
    else npass++;
  endtask

  task automatic test_raw_race();
    logic [DATA_W-1:0] got [2];
    int k, n;
    do_reset();
    k = 0; n = 0;
    bus.rd_ready = 1'b1; bus.wr_valid = 1'b1; bus.wr_data = 8'h11;
    cycle();
    bus.wr_data = 8'h22;
    cycle();
    bus.wr_valid = 1'b0;
    while (n < 12) begin
      cycle(); n++;
      if (last_pop) begin
        if (k < 2) got[k] = last_data;
        k++;
      end
    end
    ntot++;
    if (k != 2 || got[0] !== 8'h11 || got[1] !== 8'h22)
      $display("FAIL raw_race: n=%0d got %h %h want 2 11 22", k, got[0], got[1]);
    else npass++;
  endtask

  task automatic test_reset_mid();
    int n;
    logic [DATA_W-1:0] first;
    do_reset();
    bus.rd_ready = 1'b0; bus.wr_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.wr_data = 8'(8'hC0 + i);
      cycle();
    end
    bus.wr_valid = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0; #1;
    ntot++;
    if (bus.rd_valid !== 1'b0 || bus.count !== 7'd0 || bus.wr_ready !== 1'b1)
      $display("FAIL reset_mid: rd_valid=%b count=%0d wr_ready=%b want 0 0 1",
               bus.rd_valid, bus.count, bus.wr_ready);
    else npass++;
    bus.wr_valid = 1'b1; bus.wr_data = 8'h5A; bus.rd_ready = 1'b1;
    cycle();
    bus.wr_valid = 1'b0;
    n = 0; first = 8'h00;
    while (!last_pop && n < 10) begin
      cycle(); n++;
      if (last_pop) first = last_data;
    end
    ntot++;
    if (!last_pop || first !== 8'h5A)
      $display("FAIL reset_mid_first: popped=%b data=%h want 1 5a", last_pop, first);
    else npass++;
  endtask

  initial begin
    rst = 1'b1;
    bus.wr_valid = 1'b0; bus.rd_ready = 1'b0; bus.wr_data = '0;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_backpressure();
    test_raw_race();
    test_reset_mid();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
